// File: rtl/hy_riscv_regfile_arbiter.sv
// Purpose : sequencer/arbiter for the single-port 32x32 RISC-V register set (zeroing sweep, round-robin sharing, x0 rule).
// Latency : request accepted in T, register port driven in T+1, rsp_valid/rsp_rdata in T+2; one accept per cycle.
// Backpressure: req_ready grants one requester per cycle (none during INIT); no response backpressure.
//
// Ports:
//   clk, reset          rising-edge clock, asynchronous active-high reset
//   req_valid/req_we    per-requester request valid and write flag
//   req_id/req_wdata    per-requester register index (5b) and write data (32b), packed
//   req_ready           one-hot combinational grant
//   rsp_valid/rsp_rdata per-requester completion pulse, shared read data
//   init_done           high once the zeroing sweep has finished
//   rf_set_reg/rf_register_id/rf_value  registered drive of the register set
//   rf_value_in         register-set read data, combinational from rf_register_id
module hy_riscv_regfile_arbiter #(
  parameter int NUM_REQ = 3
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NUM_REQ-1:0]      req_valid,
  input  logic [NUM_REQ-1:0]      req_we,
  input  logic [5*NUM_REQ-1:0]    req_id,
  input  logic [32*NUM_REQ-1:0]   req_wdata,
  output logic [NUM_REQ-1:0]      req_ready,
  output logic [NUM_REQ-1:0]      rsp_valid,
  output logic [31:0]             rsp_rdata,
  output logic                    init_done,
  output logic                    rf_set_reg,
  output logic [4:0]              rf_register_id,
  output logic [31:0]             rf_value,
  input  logic [31:0]             rf_value_in
);

  localparam int IDXW = $clog2(NUM_REQ);
  // One extra bit so (last_grant + k) cannot overflow before the wrap.
  localparam int SW   = IDXW + 1;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t             state_q, state_d;
  logic [5:0]         cnt_q, cnt_d;
  logic               init_done_d;
  logic [IDXW-1:0]    last_grant, last_grant_d;

  // Stage-1 next values (register-port drive plus response bookkeeping)
  logic               set_d;
  logic [4:0]         rid_d;
  logic [31:0]        val_d;
  logic               s1_vld, s1_vld_d;
  logic [NUM_REQ-1:0] s1_src, s1_src_d;
  logic               s1_we, s1_we_d;
  logic               s1_x0, s1_x0_d;

  // Arbitration
  logic [SW-1:0]      cand_sum;
  logic [IDXW-1:0]    cand;
  logic               found;
  logic [IDXW-1:0]    gnt_idx;
  logic [NUM_REQ-1:0] gnt_oh;
  logic               accept;

  // Winner's request fields
  logic               sel_we;
  logic [4:0]         sel_id;
  logic [31:0]        sel_wdata;

  // ------------------------------------------------------------------
  // Round-robin search starting just above the last accepted requester.
  // The first valid requester found in the rotated order wins.
  // ------------------------------------------------------------------
  always_comb begin
    gnt_oh   = '0;
    gnt_idx  = '0;
    found    = 1'b0;
    cand_sum = '0;
    cand     = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand_sum = {1'b0, last_grant} + SW'(k);
      if (cand_sum >= SW'(NUM_REQ)) begin
        cand_sum = cand_sum - SW'(NUM_REQ);
      end
      cand = cand_sum[IDXW-1:0];
      if (!found && req_valid[cand]) begin
        found        = 1'b1;
        gnt_idx      = cand;
        gnt_oh[cand] = 1'b1;
      end
    end
  end

  // Grants are only offered once the sweep has finished.
  assign req_ready = (state_q == ST_RUN) ? gnt_oh : '0;
  assign accept    = (state_q == ST_RUN) && found;

  // AND-OR select of the granted requester's fields.
  always_comb begin
    sel_we    = 1'b0;
    sel_id    = '0;
    sel_wdata = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt_oh[i]) begin
        sel_we    = req_we[i];
        sel_id    = req_id[5*i +: 5];
        sel_wdata = req_wdata[32*i +: 32];
      end
    end
  end

  // ------------------------------------------------------------------
  // FSM next-state and stage-1 next values.
  // INIT walks indices 0..31 writing zero; once the counter reaches 32
  // the strobe drops, init_done rises and the block enters RUN.
  // ------------------------------------------------------------------
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    init_done_d  = init_done;
    last_grant_d = last_grant;
    set_d        = 1'b0;
    rid_d        = '0;
    val_d        = '0;
    s1_vld_d     = 1'b0;
    s1_src_d     = '0;
    s1_we_d      = 1'b0;
    s1_x0_d      = 1'b0;

    case (state_q)
      ST_INIT: begin
        if (cnt_q[5]) begin
          state_d     = ST_RUN;
          init_done_d = 1'b1;
        end else begin
          set_d = 1'b1;
          rid_d = cnt_q[4:0];
          cnt_d = cnt_q + 6'd1;
        end
      end

      ST_RUN: begin
        if (accept) begin
          last_grant_d = gnt_idx;
          s1_vld_d     = 1'b1;
          s1_src_d     = gnt_oh;
          s1_we_d      = sel_we;
          s1_x0_d      = (sel_id == 5'd0);
          rid_d        = sel_id;
          val_d        = sel_we ? sel_wdata : 32'd0;
          // x0 writes are acknowledged but never reach the register set.
          set_d        = sel_we && (sel_id != 5'd0);
        end
      end

      default: begin
        state_d = ST_INIT;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= ST_INIT;
      cnt_q          <= '0;
      init_done      <= 1'b0;
      last_grant     <= IDXW'(NUM_REQ - 1);
      rf_set_reg     <= 1'b0;
      rf_register_id <= '0;
      rf_value       <= '0;
      s1_vld         <= 1'b0;
      s1_src         <= '0;
      s1_we          <= 1'b0;
      s1_x0          <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      init_done      <= init_done_d;
      last_grant     <= last_grant_d;
      rf_set_reg     <= set_d;
      rf_register_id <= rid_d;
      rf_value       <= val_d;
      s1_vld         <= s1_vld_d;
      s1_src         <= s1_src_d;
      s1_we          <= s1_we_d;
      s1_x0          <= s1_x0_d;
    end
  end

  // ------------------------------------------------------------------
  // Stage 2: the register set has been addressed for a full cycle, so
  // rf_value_in is captured here. Reads of x0 are forced to zero since
  // the sweep value in x0 is not trusted to stay architectural.
  // ------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rsp_valid <= '0;
      rsp_rdata <= '0;
    end else begin
      rsp_valid <= s1_vld ? s1_src : '0;
      rsp_rdata <= (s1_vld && !s1_we && !s1_x0) ? rf_value_in : 32'd0;
    end
  end

  a_ready_onehot : assert property (@(posedge clk) disable iff (reset) $onehot0(req_ready));
  a_rsp_onehot   : assert property (@(posedge clk) disable iff (reset) $onehot0(rsp_valid));
  a_no_grant_init: assert property (@(posedge clk) disable iff (reset) !init_done |-> (req_ready == '0));

endmodule

// File: doc/hy_riscv_regfile_arbiter.md
# hy_riscv_regfile_arbiter

Sequencing and arbitration controller in front of the single-port 32 x 32-bit RISC-V general-purpose register set. After reset it zero-initialises all 32 registers with a hardware sweep. It then shares the register port among NUM_REQ requesters, for example decode, writeback and debug, using round-robin arbitration with a valid/ready request handshake and a fixed-latency response. It owns every drive of the register set's write strobe, register index and write value, and forces the architectural x0 = 0 rule that the register set does not enforce.

## Interface
- NUM_REQ, 3, number of requesters (2..8)
- clk  in  1  rising-edge clock
- reset  in  1  reset, asynchronous, active-high
- req_valid  in  NUM_REQ  per-requester request valid
- req_we  in  NUM_REQ  per-requester: 1 = write, 0 = read
- req_id  in  5*NUM_REQ  register index; requester i uses bits [5i+4:5i]
- req_wdata  in  32*NUM_REQ  write data; requester i uses bits [32i+31:32i]
- req_ready  out  NUM_REQ  one-hot grant, combinational
- rsp_valid  out  NUM_REQ  one-cycle completion pulse per requester
- rsp_rdata  out  32  read data, shared by all requesters; qualified by rsp_valid
- init_done  out  1  high once the initialisation sweep is complete
- rf_set_reg  out  1  register-set write strobe, registered
- rf_register_id  out  5  register-set index, registered
- rf_value  out  32  register-set write data, registered
- rf_value_in  in  32  register-set read data (value_out), combinational from rf_register_id

## Operation
- States: INIT and RUN. Reset enters INIT with sweep counter = 0.
- INIT:
  - At each clock edge, load rf_set_reg = 1, rf_register_id = counter and rf_value = 0, then increment the counter.
  - The sweep covers indices 0..31, including x0.
  - After index 31 has been presented, the next edge loads rf_set_reg = 0 and init_done = 1, and the block moves to RUN.
  - req_ready = 0 throughout INIT.
- RUN, arbitration:
  - req_ready is one-hot. The winner is the first requester with req_valid = 1, searching upward from (last_grant + 1) mod NUM_REQ.
  - last_grant resets to NUM_REQ-1, so requester 0 has priority first.
  - last_grant updates only on acceptance (req_valid & req_ready).
  - With no valid request, req_ready = 0.
  - req_ready never depends on the requester's own ready state; a request is accepted in the cycle it is granted.
- Stage 1, the cycle after acceptance:
  - rf_register_id = id and rf_value = wdata for a write, 0 for a read.
  - rf_set_reg = we & (id != 0). Writes to x0 are acknowledged but not performed.
  - The block registers the source index, the we flag and an x0 flag.
  - With no accept, rf_set_reg = 0 and rf_register_id / rf_value hold 0.
- Stage 2:
  - rsp_valid[src] pulses for one cycle.
  - rsp_rdata = rf_value_in as sampled at the end of stage 1 for a read, forced to 0 when id = 0, and 0 for a write.
  - rsp_rdata = 0 when no rsp_valid is asserted.
- Pipelining: fully pipelined, one accept per cycle. There is no response backpressure; requesters must consume rsp_valid when it pulses.

## Timing
- Reset values: req_ready = 0, rsp_valid = 0, rsp_rdata = 0, init_done = 0, rf_set_reg = 0, rf_register_id = 0, rf_value = 0.
- Init sweep:
  - The first edge after reset release presents x0; the 32nd edge presents x31.
  - The 33rd edge sets init_done = 1.
  - The earliest accept is the cycle following that edge.
- Latency: request accepted in cycle T; register port driven in T+1; rsp_valid in T+2.
- Read-after-write, same index:
  - A write accepted in T commits at the end of T+1.
  - A read accepted in T+1 samples in T+2 and returns the new value. No forwarding is needed.
- Simultaneous valid requests: exactly one is granted per cycle; the others hold req_valid until granted.
- Back-to-back grants to the same requester occur only if no other requester is valid.
- Reset mid-operation:
  - All pipeline contents are dropped and no rsp_valid is issued for in-flight requests.
  - Outputs return to their reset values and INIT restarts from index 0.

## Test plan
- Reset release -> rf_set_reg high for exactly 32 cycles with rf_register_id 0..31 and rf_value 0; init_done rises on the 33rd edge; req_ready stays 0 until then.
- Requester 1 writes x5 = 0xDEADBEEF, then requester 1 reads x5 in the next cycle -> read rsp_valid[1] arrives 2 cycles after its accept, with rsp_rdata = 0xDEADBEEF.
- Requester 0 writes x0 = 0x12345678, then reads x0 -> rf_set_reg stays 0 for the write; write response rsp_valid[0] with rsp_rdata = 0; read response rsp_rdata = 0.
- All three requesters hold req_valid continuously after init -> grants go 0, 1, 2, 0, 1, 2, one per cycle; each rsp_valid pulses 2 cycles after its grant.
- Requester 2 alone valid for 3 cycles while requester 0 asserts in the 2nd cycle -> grant order 2, 0, 2.
- Reset asserted in the cycle after a read is accepted -> no rsp_valid for that read; outputs return to zero; the INIT sweep restarts; a subsequent read of any register returns 0.
